// File: rtl/motor_speed_ramp.sv
`default_nettype none
// ============================================================================
// Module   : motor_speed_ramp
// Purpose  : Avalon-MM speed command stage for the DC motor PWM block. Slews
//            the applied speed toward a signed target at a programmable rate
//            and coasts at zero for a fixed interval before any reversal.
// Revision : 1.0 - initial release
// ============================================================================
module motor_speed_ramp #(
    parameter int PERIOD       = 5000,
    parameter int UPDATE_DIV   = 50000,
    parameter int REVERSE_HOLD = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        s_cs,
    input  logic [1:0]  s_address,
    input  logic        s_write,
    input  logic [31:0] s_writedata,
    input  logic        s_read,
    output logic [31:0] s_readdata,
    output logic [31:0] total_dur,
    output logic [31:0] high_dur,
    output logic        motor_go,
    output logic        motor_forward,
    output logic        motor_fast_decay,
    output logic        at_target
);

    localparam int DIV_W = (UPDATE_DIV > 1) ? $clog2(UPDATE_DIV) : 1;
    localparam logic [DIV_W-1:0]  C_DIV_LAST = DIV_W'(UPDATE_DIV - 1);
    localparam logic signed [16:0] C_PMAX    = 17'(PERIOD);
    localparam logic signed [16:0] C_PMIN    = 17'(-PERIOD);
    localparam logic [15:0]        C_HOLD    = 16'(REVERSE_HOLD);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_REV_HOLD = 2'd2
    } state_t;

    // Bus-visible configuration
    logic signed [16:0] r_target;
    logic [15:0]        r_step;
    logic               r_enable;
    logic               r_fast_decay;
    logic [31:0]        r_readdata;

    // Ramp engine state
    state_t             r_state, w_state_nxt;
    logic signed [16:0] r_current, w_current_nxt;
    logic [15:0]        r_hold, w_hold_nxt;
    logic               r_dir, w_dir_nxt;
    // Set once the motor has actually been driven; the very first ramp out of
    // reset has no previous direction to coast away from.
    logic               r_driven, w_driven_nxt;
    logic [DIV_W-1:0]   r_div;

    // Registered PWM-side outputs
    logic [31:0]        r_high_dur;
    logic               r_motor_go;
    logic               r_fast_decay_out;
    logic               r_at_target;

    logic               w_wr;
    logic               w_rd;
    logic               w_tick;
    logic signed [16:0] w_wr_raw;
    logic signed [16:0] w_wr_sat;
    logic signed [16:0] w_ramp;
    logic signed [17:0] w_cur_x, w_goal_x, w_step_x, w_up_x, w_dn_x, w_ramp_x;
    logic               w_opposite;
    logic               w_rev_needed;
    logic [16:0]        w_abs;
    logic               w_unused;

    assign w_wr     = s_cs & s_write;
    assign w_rd     = s_cs & s_read;
    assign w_tick   = (r_div == C_DIV_LAST);
    assign w_unused = &{1'b0, s_writedata[31:16]};

    // Target saturation to the PWM period on write
    always_comb begin
        w_wr_raw = {s_writedata[15], s_writedata[15:0]};
        w_wr_sat = w_wr_raw;
        if (w_wr_raw > C_PMAX)
            w_wr_sat = C_PMAX;
        else if (w_wr_raw < C_PMIN)
            w_wr_sat = C_PMIN;
    end

    // Register file writes
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_target     <= '0;
            r_step       <= 16'd1;
            r_enable     <= 1'b0;
            r_fast_decay <= 1'b1;
        end else if (w_wr) begin
            case (s_address)
                2'd0: r_target <= w_wr_sat;
                2'd1: r_step   <= s_writedata[15:0];
                2'd2: begin
                    r_enable     <= s_writedata[0];
                    r_fast_decay <= s_writedata[1];
                end
                default: ;
            endcase
        end
    end

    // Registered readback, valid the cycle after the read strobe
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_readdata <= '0;
        end else if (w_rd) begin
            case (s_address)
                2'd0:    r_readdata <= {{15{r_target[16]}}, r_target};
                2'd1:    r_readdata <= {16'd0, r_step};
                2'd2:    r_readdata <= {30'd0, r_fast_decay, r_enable};
                default: r_readdata <= {13'd0, r_at_target, 2'(r_state), r_current[15:0]};
            endcase
        end
    end

    // Free-running update divider
    always_ff @(posedge clk) begin
        if (!reset_n)
            r_div <= '0;
        else
            r_div <= w_tick ? '0 : r_div + 1'b1;
    end

    // One ramp step: head for zero while signs disagree, else for the target
    always_comb begin
        w_opposite = (r_current > 0 && r_target < 0) || (r_current < 0 && r_target > 0);
        w_cur_x    = {r_current[16], r_current};
        w_step_x   = {2'b00, r_step};
        w_goal_x   = w_opposite ? 18'sd0 : {r_target[16], r_target};
        w_up_x     = w_cur_x + w_step_x;
        w_dn_x     = w_cur_x - w_step_x;
        w_ramp_x   = w_goal_x;
        if (r_step != 16'd0) begin
            if (w_cur_x < w_goal_x)
                w_ramp_x = (w_up_x > w_goal_x) ? w_goal_x : w_up_x;
            else
                w_ramp_x = (w_dn_x < w_goal_x) ? w_goal_x : w_dn_x;
        end
        w_ramp = w_ramp_x[16:0];
    end

    assign w_rev_needed = r_driven && (r_current == 0) &&
                          ((r_target > 0 && !r_dir) || (r_target < 0 && r_dir));

    // Next-state logic for the ramp state machine
    always_comb begin
        w_state_nxt   = r_state;
        w_current_nxt = r_current;
        w_hold_nxt    = r_hold;
        w_dir_nxt     = r_dir;
        w_driven_nxt  = r_driven;

        if (r_current != 0) begin
            w_dir_nxt    = (r_current > 0);
            w_driven_nxt = 1'b1;
        end

        case (r_state)
            ST_IDLE: begin
                w_current_nxt = '0;
                if (r_enable)
                    w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (w_tick) begin
                    if (w_rev_needed) begin
                        w_state_nxt = ST_REV_HOLD;
                        w_hold_nxt  = C_HOLD;
                    end else begin
                        w_current_nxt = w_ramp;
                    end
                end
            end
            ST_REV_HOLD: begin
                w_current_nxt = '0;
                if (w_tick) begin
                    if (r_hold <= 16'd1) begin
                        w_hold_nxt  = '0;
                        w_state_nxt = ST_RUN;
                        // A zero target keeps the previous direction
                        if (r_target > 0)
                            w_dir_nxt = 1'b1;
                        else if (r_target < 0)
                            w_dir_nxt = 1'b0;
                    end else begin
                        w_hold_nxt = r_hold - 16'd1;
                    end
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_current_nxt = '0;
            end
        endcase

        // Disable wins over everything else
        if (!r_enable) begin
            w_state_nxt   = ST_IDLE;
            w_current_nxt = '0;
            w_hold_nxt    = '0;
        end
    end

    // Ramp state register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_current <= '0;
            r_hold    <= '0;
            r_dir     <= 1'b0;
            r_driven  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_current <= w_current_nxt;
            r_hold    <= w_hold_nxt;
            r_dir     <= w_dir_nxt;
            r_driven  <= w_driven_nxt;
        end
    end

    assign w_abs = r_current[16] ? (~r_current + 17'd1) : r_current;

    // PWM-side outputs, one cycle behind the ramp state
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_high_dur       <= '0;
            r_motor_go       <= 1'b0;
            r_fast_decay_out <= 1'b1;
            r_at_target      <= 1'b0;
        end else begin
            r_high_dur       <= {15'd0, w_abs};
            r_motor_go       <= r_enable && (r_state == ST_RUN) && (r_current != 0);
            r_fast_decay_out <= r_fast_decay;
            r_at_target      <= (r_state == ST_RUN) && (r_current == r_target);
        end
    end

    assign s_readdata       = r_readdata;
    assign total_dur        = 32'(PERIOD);
    assign high_dur         = r_high_dur;
    assign motor_go         = r_motor_go;
    assign motor_forward    = r_dir;
    assign motor_fast_decay = r_fast_decay_out;
    assign at_target        = r_at_target;

endmodule
`default_nettype wire

// File: tb/tb_motor_speed_ramp.sv
`default_nettype none
// ============================================================================
// Module   : tb_motor_speed_ramp
// Purpose  : Self-checking bench for motor_speed_ramp: directed scenarios plus
//            random bus traffic against a speed-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_motor_speed_ramp;

    localparam int PERIOD       = 100;
    localparam int UPDATE_DIV   = 4;
    localparam int REVERSE_HOLD = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        s_cs = 1'b0;
    logic [1:0]  s_address = 2'd0;
    logic        s_write = 1'b0;
    logic [31:0] s_writedata = 32'd0;
    logic        s_read = 1'b0;
    logic [31:0] s_readdata;
    logic [31:0] total_dur;
    logic [31:0] high_dur;
    logic        motor_go;
    logic        motor_forward;
    logic        motor_fast_decay;
    logic        at_target;

    always #5 clk = ~clk;

    motor_speed_ramp #(
        .PERIOD(PERIOD), .UPDATE_DIV(UPDATE_DIV), .REVERSE_HOLD(REVERSE_HOLD)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .s_cs(s_cs), .s_address(s_address), .s_write(s_write),
        .s_writedata(s_writedata), .s_read(s_read), .s_readdata(s_readdata),
        .total_dur(total_dur), .high_dur(high_dur), .motor_go(motor_go),
        .motor_forward(motor_forward), .motor_fast_decay(motor_fast_decay),
        .at_target(at_target)
    );

    int total = 0;
    int bad = 0;

    // Reference model: speeds as plain integers, mode 0 idle / 1 run / 2 coast
    int          m_tgt, m_step, m_cur, m_mode, m_hold, m_div;
    bit          m_en, m_fdc, m_dir, m_drv;
    int          m_high;
    bit          m_go, m_fd, m_at;
    logic [31:0] m_rdata;

    // Observation of high_dur changes
    int seq[$];
    int exp_q[$];
    int last_high = 0;
    int zero_cnt = 0;
    int go_bad = 0;
    bit first_fwd, first_go;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int approach(int cur, int tgt, int step);
        int goal;
        goal = ((cur > 0 && tgt < 0) || (cur < 0 && tgt > 0)) ? 0 : tgt;
        if (step == 0) return goal;
        if (cur < goal) return (cur + step > goal) ? goal : cur + step;
        return (cur - step < goal) ? goal : cur - step;
    endfunction

    function automatic int sat(logic [15:0] v);
        int x;
        x = $signed(v);
        if (x > PERIOD) x = PERIOD;
        if (x < -PERIOD) x = -PERIOD;
        return x;
    endfunction

    function automatic logic [31:0] read_value(logic [1:0] a);
        logic [31:0] v;
        v = 32'd0;
        case (a)
            2'd0: v = m_tgt;
            2'd1: v = m_step;
            2'd2: begin v[0] = m_en; v[1] = m_fdc; end
            default: begin
                v[15:0]  = m_cur[15:0];
                v[17:16] = m_mode[1:0];
                v[18]    = m_at;
            end
        endcase
        return v;
    endfunction

    task automatic model_reset();
        m_tgt = 0; m_step = 1; m_cur = 0; m_mode = 0; m_hold = 0; m_div = 0;
        m_en = 0; m_fdc = 1; m_dir = 0; m_drv = 0;
        m_high = 0; m_go = 0; m_fd = 1; m_at = 0; m_rdata = 32'd0;
    endtask

    task automatic model_edge();
        bit tick;
        int n_cur, n_mode, n_hold;
        bit n_dir, n_drv;
        tick = (m_div == UPDATE_DIV - 1);
        n_cur = m_cur; n_mode = m_mode; n_hold = m_hold; n_dir = m_dir; n_drv = m_drv;
        if (s_cs && s_read) m_rdata = read_value(s_address);
        m_high = (m_cur < 0) ? -m_cur : m_cur;
        m_go   = m_en && (m_mode == 1) && (m_cur != 0);
        m_fd   = m_fdc;
        m_at   = (m_mode == 1) && (m_cur == m_tgt);
        if (m_cur != 0) begin n_dir = (m_cur > 0); n_drv = 1; end
        if (m_mode == 0) begin
            n_cur = 0;
            if (m_en) n_mode = 1;
        end else if (m_mode == 1) begin
            if (tick) begin
                if (m_cur == 0 && m_drv && m_tgt != 0 && ((m_tgt > 0) != m_dir)) begin
                    n_mode = 2; n_hold = REVERSE_HOLD;
                end else begin
                    n_cur = approach(m_cur, m_tgt, m_step);
                end
            end
        end else begin
            n_cur = 0;
            if (tick) begin
                n_hold = m_hold - 1;
                if (n_hold <= 0) begin
                    n_hold = 0; n_mode = 1;
                    if (m_tgt != 0) n_dir = (m_tgt > 0);
                end
            end
        end
        if (!m_en) begin n_mode = 0; n_cur = 0; n_hold = 0; end
        if (s_cs && s_write) begin
            case (s_address)
                2'd0: m_tgt = sat(s_writedata[15:0]);
                2'd1: m_step = int'(s_writedata[15:0]);
                2'd2: begin m_en = s_writedata[0]; m_fdc = s_writedata[1]; end
                default: ;
            endcase
        end
        m_div = tick ? 0 : m_div + 1;
        m_cur = n_cur; m_mode = n_mode; m_hold = n_hold; m_dir = n_dir; m_drv = n_drv;
    endtask

    // One clock: advance the model, then compare every output away from the edge
    task automatic cycle();
        @(posedge clk);
        if (!reset_n) model_reset(); else model_edge();
        #1;
        check_val("high_dur", high_dur, 32'(m_high));
        check_val("motor_go", 32'(motor_go), 32'(m_go));
        check_val("motor_forward", 32'(motor_forward), 32'(m_dir));
        check_val("motor_fast_decay", 32'(motor_fast_decay), 32'(m_fd));
        check_val("at_target", 32'(at_target), 32'(m_at));
        check_val("total_dur", total_dur, 32'(PERIOD));
        check_val("s_readdata", s_readdata, m_rdata);
        if (int'(high_dur) != last_high) begin
            seq.push_back(int'(high_dur));
            last_high = int'(high_dur);
            if (seq.size() == 1) begin first_fwd = motor_forward; first_go = motor_go; end
        end
        if (high_dur == 32'd0) begin
            zero_cnt++;
            if (motor_go) go_bad++;
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        s_cs = 1'b1; s_write = 1'b1; s_address = a; s_writedata = d;
        cycle();
        s_cs = 1'b0; s_write = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] v);
        s_cs = 1'b1; s_read = 1'b1; s_address = a;
        cycle();
        s_cs = 1'b0; s_read = 1'b0;
        v = s_readdata;
    endtask

    task automatic watch(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic clear_obs();
        seq.delete();
        zero_cnt = 0;
        go_bad = 0;
    endtask

    task automatic check_seq(input string tag);
        check_val({tag, "_len"}, 32'(seq.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < seq.size(); i++)
            check_val(tag, 32'(seq[i]), 32'(exp_q[i]));
    endtask

    task automatic wait_high(input int val, input int budget);
        int n;
        n = 0;
        while (int'(high_dur) != val && n < budget) begin
            cycle();
            n++;
        end
        check_val("wait_high", high_dur, 32'(val));
    endtask

    task automatic check_reset_state();
        logic [31:0] v;
        check_val("rst_high_dur", high_dur, 32'd0);
        check_val("rst_motor_go", 32'(motor_go), 32'd0);
        check_val("rst_forward", 32'(motor_forward), 32'd0);
        check_val("rst_fast_decay", 32'(motor_fast_decay), 32'd1);
        check_val("rst_at_target", 32'(at_target), 32'd0);
        check_val("rst_total_dur", total_dur, 32'd100);
        check_val("rst_readdata", s_readdata, 32'd0);
        bus_read(2'd3, v); check_val("rst_status", v, 32'd0);
        bus_read(2'd0, v); check_val("rst_target", v, 32'd0);
        bus_read(2'd1, v); check_val("rst_step", v, 32'd1);
        bus_read(2'd2, v); check_val("rst_config", v, 32'd2);
    endtask

    initial begin
        logic [31:0] v;
        int op, n;
        model_reset();

        // Reset then idle
        reset_n = 1'b0;
        watch(3);
        reset_n = 1'b1;
        check_reset_state();

        // Forward ramp
        clear_obs();
        bus_write(2'd1, 32'd10);
        bus_write(2'd0, 32'd35);
        bus_write(2'd2, 32'd1);
        watch(30);
        exp_q = {10, 20, 30, 35};
        check_seq("fwd_ramp");
        check_val("fwd_first_forward", 32'(first_fwd), 32'd1);
        check_val("fwd_first_go", 32'(first_go), 32'd1);
        check_val("fwd_at_target", 32'(at_target), 32'd1);

        // Reversal with coast interval
        clear_obs();
        bus_write(2'd0, 32'hFFFF_FFEC);
        watch(60);
        exp_q = {25, 15, 5, 0, 10, 20};
        check_seq("rev_ramp");
        check_val("rev_zero_cycles", 32'(zero_cnt), 32'd16);
        check_val("rev_go_at_zero", 32'(go_bad), 32'd0);
        check_val("rev_forward", 32'(motor_forward), 32'd0);
        check_val("rev_at_target", 32'(at_target), 32'd1);

        // Saturation and step 0 jump
        clear_obs();
        bus_write(2'd1, 32'd0);
        bus_write(2'd0, 32'h0000_FE0C);
        bus_read(2'd0, v);
        check_val("sat_neg_readback", v, 32'hFFFF_FF9C);
        watch(8);
        exp_q = {100};
        check_seq("jump_neg");
        clear_obs();
        bus_write(2'd0, 32'd500);
        bus_read(2'd0, v);
        check_val("sat_pos_readback", v, 32'd100);
        watch(40);
        exp_q = {0, 100};
        check_seq("jump_rev");
        check_val("jump_rev_zero_cycles", 32'(zero_cnt), 32'd16);
        check_val("jump_rev_forward", 32'(motor_forward), 32'd1);

        // Disable mid-ramp, then re-enable
        bus_write(2'd0, 32'd20);
        wait_high(20, 20);
        bus_write(2'd2, 32'd0);
        cycle();
        check_val("dis_high_lag", high_dur, 32'd20);
        check_val("dis_go", 32'(motor_go), 32'd0);
        cycle();
        check_val("dis_high", high_dur, 32'd0);
        clear_obs();
        bus_write(2'd1, 32'd5);
        bus_write(2'd2, 32'd1);
        watch(30);
        exp_q = {5, 10, 15, 20};
        check_seq("reenable_ramp");

        // Reset while coasting before a reversal
        bus_write(2'd1, 32'd0);
        bus_write(2'd0, 32'hFFFF_FFE2);
        n = 0;
        while (m_mode != 2 && n < 40) begin cycle(); n++; end
        check_val("reach_rev_hold", 32'(m_mode), 32'd2);
        reset_n = 1'b0;
        watch(2);
        reset_n = 1'b1;
        check_reset_state();

        // Random bus traffic
        bus_write(2'd2, 32'd1);
        bus_write(2'd1, 32'($urandom_range(1, 20)));
        for (int i = 0; i < 2500; i++) begin
            op = $urandom_range(0, 99);
            if (op < 6) begin
                if ($urandom_range(0, 9) == 0) bus_write(2'd0, $urandom);
                else bus_write(2'd0, 32'($urandom_range(0, 300)) - 32'd150);
            end else if (op < 10) begin
                if ($urandom_range(0, 4) == 0) bus_write(2'd1, 32'd0);
                else bus_write(2'd1, 32'($urandom_range(1, 30)));
            end else if (op < 13) begin
                v = 32'($urandom_range(0, 3));
                if ($urandom_range(0, 99) < 85) v[0] = 1'b1;
                bus_write(2'd2, v);
            end else if (op < 25) begin
                bus_read(2'($urandom_range(0, 3)), v);
            end else if (op < 28) begin
                bus_write(2'd3, $urandom);
            end else if (op < 30) begin
                s_cs = 1'b0; s_write = 1'b1; s_address = 2'($urandom_range(0, 2));
                s_writedata = $urandom;
                cycle();
                s_write = 1'b0;
            end else begin
                cycle();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
